// File: rtl/fifo_uart_tx.sv
// Drains words from an upstream FIFO and serialises each one as a UART frame:
// start bit, DATA_WIDTH bits LSB first, optional even parity, then a stop bit.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  FIFO_EMPTY,
  input  logic                  FIFO_WR_EN,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  output logic                  FIFO_RD_EN,
  output logic                  TXD,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  par_bit;
  logic                  baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Read is suppressed during an upstream write because the FIFO would drop it.
  assign FIFO_RD_EN = (state == IDLE) && EN && !FIFO_EMPTY && !FIFO_WR_EN && RST_N;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      shreg      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      TXD        <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (FIFO_RD_EN) begin
            state <= FETCH;
            BUSY  <= 1'b1;
          end
        end
        // Registered FIFO data is valid here, one cycle after the read.
        FETCH: begin
          shreg    <= FIFO_DOUT;
          par_bit  <= ^FIFO_DOUT;
          TXD      <= 1'b0;
          bit_cnt  <= '0;
          baud_cnt <= '0;
          state    <= START;
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            TXD      <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                TXD   <= par_bit;
                state <= PARITY;
              end else begin
                TXD   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              TXD     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            TXD      <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt   <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b1;
            state      <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4: one instance without
// parity and one with parity, sharing the FIFO model but with separate enables.
module tb_fifo_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       en_a;
  logic       en_p;
  logic       fifo_empty;
  logic       fifo_wr_en;
  logic [7:0] fifo_dout;
  logic       rd_a, txd_a, busy_a, done_a;
  logic       rd_p, txd_p, busy_p, done_p;

  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  logic [7:0] q[$];

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en_a), .FIFO_EMPTY(fifo_empty),
    .FIFO_WR_EN(fifo_wr_en), .FIFO_DOUT(fifo_dout), .FIFO_RD_EN(rd_a),
    .TXD(txd_a), .BUSY(busy_a), .FRAME_DONE(done_a)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
    .CLK(clk), .RST_N(rst_n), .EN(en_p), .FIFO_EMPTY(fifo_empty),
    .FIFO_WR_EN(fifo_wr_en), .FIFO_DOUT(fifo_dout), .FIFO_RD_EN(rd_p),
    .TXD(txd_p), .BUSY(busy_p), .FRAME_DONE(done_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock; the FIFO model pops on an accepted read and presents registered data.
  task automatic tick();
    logic rd_now;
    #1;
    rd_now = rd_a | rd_p;
    @(posedge clk);
    #1;
    if (rd_now && !fifo_wr_en) begin
      rd_pulses++;
      if (q.size() > 0) fifo_dout = q.pop_front();
    end
    fifo_empty = (q.size() == 0);
    if (done_a | done_p) done_pulses++;
  endtask

  function automatic logic cur_txd(input bit p);
    return p ? txd_p : txd_a;
  endfunction

  function automatic logic cur_busy(input bit p);
    return p ? busy_p : busy_a;
  endfunction

  function automatic logic cur_done(input bit p);
    return p ? done_p : done_a;
  endfunction

  // Waits for the start bit, checks every bit period, and ends on the first IDLE cycle.
  task automatic frame(input bit p, input logic [7:0] w, input string tag, output int waited);
    int   k;
    int   good;
    int   nslots;
    logic e;
    k = 0;
    while (cur_txd(p) !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    waited = k;
    check({tag, " start"}, 32'(k < 20), 32'd1);
    nslots = p ? 11 : 10;
    for (int s = 0; s < nslots; s++) begin
      if (s == 0) e = 1'b0;
      else if (s <= 8) e = w[s-1];
      else if (p && s == 9) e = ^w;
      else e = 1'b1;
      good = 0;
      for (int c = 0; c < 4; c++) begin
        if (cur_txd(p) === e && cur_busy(p) === 1'b1) good++;
        tick();
      end
      check($sformatf("%s slot%0d", tag, s), 32'(good), 32'd4);
    end
    check({tag, " done"}, 32'(cur_done(p)), 32'd1);
    check({tag, " idle busy"}, 32'(cur_busy(p)), 32'd0);
    check({tag, " idle txd"}, 32'(cur_txd(p)), 32'd1);
  endtask

  initial begin
    int r0;
    int d0;
    int k;
    rst_n      = 1'b0;
    en_a       = 1'b1;
    en_p       = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_dout  = 8'h00;
    fifo_empty = 1'b1;
    push(8'hA5);

    // Reset with data available and enable high
    repeat (3) tick();
    check("rst txd", 32'(txd_a), 32'd1);
    check("rst rd", 32'(rd_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst txd_p", 32'(txd_p), 32'd1);

    // Single word 0xA5
    r0 = rd_pulses;
    d0 = done_pulses;
    rst_n = 1'b1;
    #1;
    check("release rd", 32'(rd_a), 32'd1);
    frame(1'b0, 8'hA5, "single", k);
    check("single rd count", 32'(rd_pulses - r0), 32'd1);
    check("single done count", 32'(done_pulses - d0), 32'd1);
    tick();
    check("single done width", 32'(done_a), 32'd0);
    repeat (2) tick();
    check("empty no rd", 32'(rd_a), 32'd0);
    check("empty busy", 32'(busy_a), 32'd0);

    // Write collision holds off the read
    fifo_wr_en = 1'b1;
    push(8'h3C);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("collide rd%0d", i), 32'(rd_a), 32'd0);
      tick();
    end
    fifo_wr_en = 1'b0;
    #1;
    check("collide release rd", 32'(rd_a), 32'd1);
    r0 = rd_pulses;
    frame(1'b0, 8'h3C, "collide", k);
    check("collide rd count", 32'(rd_pulses - r0), 32'd1);

    // Parity instance, word 0x07 (odd weight -> parity bit 1)
    en_a = 1'b0;
    en_p = 1'b1;
    push(8'h07);
    frame(1'b1, 8'h07, "parity", k);
    check("parity other idle", 32'(busy_a), 32'd0);
    en_p = 1'b0;
    en_a = 1'b1;

    // Back-to-back 0x00 then 0xFF
    d0 = done_pulses;
    push(8'h00);
    push(8'hFF);
    frame(1'b0, 8'h00, "b2b0", k);
    frame(1'b0, 8'hFF, "b2b1", k);
    check("b2b gap", 32'(4 + k), 32'd6);
    check("b2b done count", 32'(done_pulses - d0), 32'd2);

    // Reset during data bit 3 of 0x55, then resume with 0x81
    push(8'h55);
    push(8'h81);
    d0 = done_pulses;
    k = 0;
    while (txd_a !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    repeat (17) tick();
    check("abort pre txd", 32'(txd_a), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort txd", 32'(txd_a), 32'd1);
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort done", 32'(done_a), 32'd0);
    check("abort rd", 32'(rd_a), 32'd0);
    repeat (2) tick();
    check("abort no done", 32'(done_pulses - d0), 32'd0);
    rst_n = 1'b1;
    #1;
    check("abort release rd", 32'(rd_a), 32'd1);
    frame(1'b0, 8'h81, "resume", k);
    check("resume done count", 32'(done_pulses - d0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
